// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix in a final cycle.
// Optional macro RV_MDU_EARLY_OUT_EN shortens multiplies to the significant bits of |b|.
module rv_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           op_q, op_d;
   logic                 neg_q, neg_d;
   logic                 spec_q, spec_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 done_q, done_d;

   logic                 a_signed, b_signed, sa, sb, b_zero, ovf;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       rem_sh, sub;
   logic                 ge;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

`ifdef RV_MDU_EARLY_OUT_EN
   function automatic logic [CW-1:0] mul_iters(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = CW'(1);
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) n = CW'(i + 1);
      end
      return n;
   endfunction
`endif

   // Operand decode; a most-negative value becomes the unsigned magnitude 2^(WIDTH-1).
   always_comb begin
      a_signed = ~(op[0] & (op[1] | op[2]));
      b_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      sa       = a_signed & a[WIDTH-1];
      sb       = b_signed & b[WIDTH-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
      b_zero   = (b == '0);
      ovf      = op[2] & ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == {WIDTH{1'b1}});
   end

   always_comb begin
      rem_sh   = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
      ge       = (rem_sh >= {1'b0, y_q});
      sub      = rem_sh - {1'b0, y_q};
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -x_q[WIDTH-1:0] : x_q[WIDTH-1:0];
      rem_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      spec_d   = spec_q;
      acc_d    = acc_q;
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = op;
               spec_d = 1'b0;
               acc_d  = '0;
               x_d    = {{WIDTH{1'b0}}, mag_a};
               y_d    = mag_b;
               // Remainder follows the dividend; quotient and products follow the sign xor.
               neg_d  = (op[2] & op[1]) ? sa : (sa ^ sb);
               if (op[2] && b_zero) begin
                  spec_d  = 1'b1;
                  acc_d   = {{WIDTH{1'b0}}, (op[1] ? a : {WIDTH{1'b1}})};
                  state_d = S_FIX;
               end else if (ovf) begin
                  spec_d  = 1'b1;
                  acc_d   = {{WIDTH{1'b0}}, (op[1] ? {WIDTH{1'b0}} : a)};
                  state_d = S_FIX;
               end else begin
                  state_d = S_CALC;
`ifdef RV_MDU_EARLY_OUT_EN
                  cnt_d   = op[2] ? CW'(WIDTH) : mul_iters(mag_b);
`else
                  cnt_d   = CW'(WIDTH);
`endif
               end
            end
         end
         S_CALC: begin
            if (!op_q[2]) begin
               if (y_q[0]) acc_d = acc_q + x_q;
               x_d = x_q << 1;
               y_d = y_q >> 1;
            end else begin
               acc_d[WIDTH:0]   = ge ? sub : rem_sh;
               x_d[WIDTH-1:0]   = {x_q[WIDTH-2:0], ge};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (spec_q)
               result_d = acc_q[WIDTH-1:0];
            else if (!op_q[2])
               result_d = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
            else
               result_d = op_q[1] ? rem_fix : quo_fix;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         spec_q   <= 1'b0;
         acc_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         spec_q   <= spec_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         y_q      <= y_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: doc/rv_mdu.md
Name: rv_mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M funct3 operation set, generalised over datapath width.
- Sits beside the ALU in the next-generation core: the control unit raises start for OP/funct7=0000001 instructions and stalls the PC until done.
- Multiply uses radix-2 shift-add on magnitudes; divide uses restoring division on magnitudes; the sign fix is applied in a final cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are 4 or greater.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  WIDTH  rs1 operand (multiplicand/dividend)
- b  in  WIDTH  rs2 operand (multiplier/divisor)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; result is valid from this cycle on
- result  out  WIDTH  registered result, held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal operand registers=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge k: latch op, the operand magnitudes, and the result-sign flags; busy=1 from this edge.
  - If the operation is normal, go to CALC with counter=WIDTH.
  - If it is a special divide case, go directly to FIX.
- CALC: one iteration per edge. Decrement the counter. When the counter reaches 0 (edge k+WIDTH), go to FIX.
- FIX: apply the sign correction, write result, set done=1 and busy=0, then return to IDLE. This happens at edge k+WIDTH+1.
- Latency: done is high in the cycle after edge k+WIDTH+1 for normal operations. For special cases it is high after edge k+1.
- done: deasserts at the next edge. A new start may be accepted in the same cycle that done is high.
- start while busy: ignored. Latched operands and op are unaffected.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
- Product register: 2*WIDTH bits. MUL returns product[WIDTH-1:0]. MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH] after the sign fix.
- Result signs:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - A most-negative magnitude is handled as unsigned 2^(WIDTH-1), so no overflow occurs inside CALC.
- Special cases, decided in IDLE:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a=most negative, b=-1): DIV returns a; REM returns 0.
- Reset mid-operation: returns to IDLE on that edge. The partial result is discarded, result=0, and no done pulse is produced.
- Counter width: $clog2(WIDTH+1) bits.

Optional Feature:
- Macro: RV_MDU_EARLY_OUT_EN.
- Defined: for multiply ops, CALC performs n iterations, where n = (index of the highest set bit of |b|) + 1, with a minimum of 1 (|b| taken under the op's signedness). done is then high after edge k+n+1. Divide latency is unchanged.
- Undefined: every non-special operation takes exactly WIDTH CALC cycles. Results are identical either way.

Test Plan:
- Signed MUL, WIDTH=32: a=7, b=0xFFFFFFFD, MUL, start at edge k -> result=0xFFFFFFEB. done high only after edge k+33. busy high for edges k..k+32.
- High-half multiplies: a=b=0x80000000 with MULH -> 0x40000000; MULHU -> 0x40000000. a=b=0xFFFFFFFF with MULHSU -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE.
- Divide and remainder:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
  - REM of the same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - Each completes with done after edge k+33.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - All four have done after edge k+1.
- Busy and reset:
  - start with new operands while busy -> ignored; the original result is delivered.
  - rst at edge k+10 of an operation -> busy=0, done=0, result=0 after that edge, no late done pulse.
  - start on the next edge is accepted normally.
- With RV_MDU_EARLY_OUT_EN:
  - MUL 3*5 -> 15 with done after edge k+4.
  - MUL 9*0 -> 0 with done after edge k+2.
  - DIVU 100/7 still has done after edge k+33.
